// File: rtl/def.sv
// Shared memory-request definitions used by the arbiter and its clients.
package def;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    logic                    mode;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] wstrb;
  } mem_req_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_e;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep request holding slot: captures a request and flags it pending
// until the arbiter issues it.
module mem_req_slot
  import def::*;
#(
  parameter int W = $bits(mem_req_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         pending,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      q       <= '0;
    end else begin
      if (set) q <= d;
      // clear wins: a request granted in its arrival cycle never lingers
      if (clear)    pending <= 1'b0;
      else if (set) pending <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing the single-pulse memory request
// bus between the core path (port 0) and the virtio DMA engine (port 1).
module mem_arbiter
  import def::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_request_enable,
  input  logic                m0_mode,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_response_enable,
  output logic [DATA_W-1:0]   m0_data,
  input  logic                m1_request_enable,
  input  logic                m1_mode,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_response_enable,
  output logic [DATA_W-1:0]   m1_data,
  output logic                mem_request_enable,
  output logic                mem_mode,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_response_enable,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                busy,
  output logic                owner,
  output logic                protocol_error
);

  localparam int S_W = 1 + ADDR_W + DATA_W + DATA_W / 8;

  arb_state_e state, state_nxt;

  logic [S_W-1:0] req_in [2];
  logic [S_W-1:0] slot_q [2];
  logic [S_W-1:0] grant_data;
  logic [1:0]     req_en, pend, outst, accept, cand, clr;
  logic           rsp_fire, arb_en, grant_any, grant_port, last_grant;

  assign req_in[0] = {m0_mode, m0_addr, m0_wdata, m0_wstrb};
  assign req_in[1] = {m1_mode, m1_addr, m1_wdata, m1_wstrb};
  assign req_en    = {m1_request_enable, m0_request_enable};

  assign busy     = (state == ARB_WAIT);
  assign rsp_fire = busy && mem_response_enable;
  assign arb_en   = !busy || rsp_fire;

  assign outst  = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign accept = req_en & ~pend & ~outst;
  assign cand   = pend | accept;

  assign grant_any  = arb_en && (|cand);
  assign grant_port = (&cand) ? ~last_grant : cand[1];
  assign clr        = grant_any ? (grant_port ? 2'b10 : 2'b01) : 2'b00;

  // a request may be granted in the cycle it arrives, before the slot holds it
  assign grant_data = pend[grant_port] ? slot_q[grant_port]
                                       : req_in[grant_port];

  for (genvar i = 0; i < 2; i++) begin : g_slot
    mem_req_slot #(.W(S_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .set     (accept[i]),
      .clear   (clr[i]),
      .d       (req_in[i]),
      .pending (pend[i]),
      .q       (slot_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (|cand) state_nxt = ARB_WAIT;
      ARB_WAIT: if (rsp_fire) state_nxt = (|cand) ? ARB_WAIT : ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_request_enable <= 1'b0;
      mem_mode           <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_wstrb          <= '0;
      owner              <= 1'b0;
      last_grant         <= 1'b1;
      m0_response_enable <= 1'b0;
      m1_response_enable <= 1'b0;
      m0_data            <= '0;
      m1_data            <= '0;
      protocol_error     <= 1'b0;
    end else begin
      mem_request_enable <= grant_any;
      if (grant_any) begin
        {mem_mode, mem_addr, mem_wdata, mem_wstrb} <= grant_data;
        owner      <= grant_port;
        last_grant <= grant_port;
      end
      m0_response_enable <= rsp_fire && !owner;
      m1_response_enable <= rsp_fire && owner;
      if (rsp_fire && !owner) m0_data <= mem_data;
      if (rsp_fire && owner)  m1_data <= mem_data;
      if (|(req_en & ~accept)) protocol_error <= 1'b1;
    end
  end

endmodule
